// File: rtl/bus_arbiter.sv
// bus_arbiter: three-requester arbiter (bit0 data, bit1 code, bit2 page
// walker) in front of a single downstream bus with one outstanding transfer.
//
// Optional build macro: BUS_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin winner selection starting after the last IDLE grant
//   undefined -> fixed priority bit0 > bit1 > bit2
//
// Parameters
//   TIMEOUT_CYCLES  WAIT cycles without i_bus_ready before abort (1..255)
// Ports
//   i_clock, i_reset_n          clock, synchronous active-low reset
//   i_req_vaild/_write_enable/_lock [2:0]   per-requester controls
//   i_req_address/_data_write   [95:0]      requester k at [32k+31:32k]
//   o_req_ready [2:0]           one-cycle completion pulse to the owner
//   o_req_data_read, o_req_error  response data / timeout flag
//   o_grant [2:0]               one-hot owner, 0 when idle
//   o_bus_*, i_bus_*            downstream bus interface
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [2:0]  i_req_vaild,
  output logic [2:0]  o_req_ready,
  input  logic [2:0]  i_req_write_enable,
  input  logic [2:0]  i_req_lock,
  input  logic [95:0] i_req_address,
  input  logic [95:0] i_req_data_write,
  output logic [31:0] o_req_data_read,
  output logic        o_req_error,
  output logic [2:0]  o_grant,
  output logic        o_bus_vaild,
  output logic        o_bus_write_enable,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_data_write,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_data_read
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t          state;
  logic [7:0]      wait_cnt;
  logic [1:0]      owner;
  logic [2:0][31:0] req_addr, req_wdata;
  logic [1:0]      win_idx, issue_idx;
  logic            win_any, issue;

  assign req_addr  = i_req_address;
  assign req_wdata = i_req_data_write;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  // rr_ptr holds the last requester granted from IDLE; search starts one above.
  logic [1:0] rr_ptr;
  logic [1:0] cand;

  always_comb begin
    win_idx = 2'd0;
    win_any = 1'b0;
    cand    = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      cand = 2'((32'(rr_ptr) + 32'(i)) % 32'd3);
      if (!win_any && i_req_vaild[cand]) begin
        win_idx = cand;
        win_any = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_any = |i_req_vaild;
    if (i_req_vaild[0])      win_idx = 2'd0;
    else if (i_req_vaild[1]) win_idx = 2'd1;
    else                     win_idx = 2'd2;
  end
`endif

  // In HOLD only the locked owner may issue; everyone else stalls.
  assign issue_idx = (state == S_HOLD) ? owner : win_idx;
  assign issue     = ((state == S_IDLE) && win_any) ||
                     ((state == S_HOLD) && i_req_vaild[owner]);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state              <= S_IDLE;
      wait_cnt           <= 8'd0;
      owner              <= 2'd0;
      o_bus_vaild        <= 1'b0;
      o_bus_write_enable <= 1'b0;
      o_bus_address      <= 32'd0;
      o_bus_data_write   <= 32'd0;
      o_req_ready        <= 3'b000;
      o_req_data_read    <= 32'd0;
      o_req_error        <= 1'b0;
      o_grant            <= 3'b000;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      rr_ptr             <= 2'd2;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!win_any) begin
            o_bus_vaild <= 1'b0;
            o_grant     <= 3'b000;
          end
        end
        S_WAIT: begin
          // Ready takes precedence over a timeout landing on the same cycle.
          if (i_bus_ready) begin
            o_bus_vaild     <= 1'b0;
            o_req_data_read <= i_bus_data_read;
            o_req_ready     <= 3'b001 << owner;
            o_req_error     <= 1'b0;
            state           <= S_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            o_bus_vaild     <= 1'b0;
            o_req_data_read <= 32'hFFFF_FFFF;
            o_req_ready     <= 3'b001 << owner;
            o_req_error     <= 1'b1;
            state           <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          o_req_ready <= 3'b000;
          o_req_error <= 1'b0;
          if (i_req_lock[owner]) begin
            state <= S_HOLD;
          end else begin
            state   <= S_IDLE;
            o_grant <= 3'b000;
          end
        end
        S_HOLD: begin
          // Lock dropped with a request still pending: issue serves it as the
          // final transfer and RESP then releases the bus.
          if (!i_req_vaild[owner] && !i_req_lock[owner]) begin
            state   <= S_IDLE;
            o_grant <= 3'b000;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        state              <= S_WAIT;
        wait_cnt           <= 8'd0;
        owner              <= issue_idx;
        o_grant            <= 3'b001 << issue_idx;
        o_bus_vaild        <= 1'b1;
        o_bus_write_enable <= i_req_write_enable[issue_idx];
        o_bus_address      <= req_addr[issue_idx];
        o_bus_data_write   <= req_wdata[issue_idx];
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        if (state == S_IDLE) rr_ptr <= issue_idx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (TIMEOUT_CYCLES=4). Table of isolated
// transfers plus hand sequences for lock, reset mid-WAIT, contention, timeout.
// Response expectations go through a queue checked whenever o_req_ready pulses.
module tb_bus_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic [2:0]  i_req_vaild, i_req_write_enable, i_req_lock;
  logic [95:0] i_req_address, i_req_data_write;
  logic [2:0]  o_req_ready, o_grant;
  logic [31:0] o_req_data_read, o_bus_address, o_bus_data_write;
  logic        o_req_error, o_bus_vaild, o_bus_write_enable;
  logic        i_bus_ready;
  logic [31:0] i_bus_data_read;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_req_vaild(i_req_vaild), .o_req_ready(o_req_ready),
    .i_req_write_enable(i_req_write_enable), .i_req_lock(i_req_lock),
    .i_req_address(i_req_address), .i_req_data_write(i_req_data_write),
    .o_req_data_read(o_req_data_read), .o_req_error(o_req_error),
    .o_grant(o_grant), .o_bus_vaild(o_bus_vaild),
    .o_bus_write_enable(o_bus_write_enable), .o_bus_address(o_bus_address),
    .o_bus_data_write(o_bus_data_write), .i_bus_ready(i_bus_ready),
    .i_bus_data_read(i_bus_data_read)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic [2:0]  exp_grant;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [2:0]  ready;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every ready pulse must match the oldest expectation.
  always @(negedge i_clock) begin
    if (o_req_ready != 3'b000) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got %b expected none", o_req_ready);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_ready", 32'(o_req_ready), 32'(e.ready));
        chk("resp_rdata", o_req_data_read, e.rdata);
        chk("resp_err", 32'(o_req_error), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic we,
                         input logic lk, input logic [31:0] a, input logic [31:0] d);
    i_req_vaild[idx]        = v;
    i_req_write_enable[idx] = we;
    i_req_lock[idx]         = lk;
    i_req_address[32*idx +: 32]    = a;
    i_req_data_write[32*idx +: 32] = d;
  endtask

  task automatic wait_bus();
    int k = 0;
    while (!o_bus_vaild && k < 20) begin
      step();
      k++;
    end
    chk("bus_wait", 32'(o_bus_vaild), 32'd1);
  endtask

  task automatic xfer(input vec_t v);
    logic [2:0] g;
    g = 3'b001 << v.idx;
    set_req(v.idx, 1'b1, v.we, 1'b0, v.addr, v.wdata);
    step();
    chk("issue_vld", 32'(o_bus_vaild), 32'd1);
    chk("issue_grant", 32'(o_grant), 32'(v.exp_grant));
    chk("issue_addr", o_bus_address, v.addr);
    chk("issue_we", 32'(o_bus_write_enable), 32'(v.we));
    chk("issue_wdata", o_bus_data_write, v.wdata);
    repeat (v.delay) step();
    chk("hold_vld", 32'(o_bus_vaild), 32'd1);
    chk("hold_addr", o_bus_address, v.addr);
    i_bus_ready = 1'b1;
    i_bus_data_read = v.rdata;
    sb.push_back('{g, v.rdata, v.exp_err});
    step();
    i_bus_ready = 1'b0;
    chk("drop_vld", 32'(o_bus_vaild), 32'd0);
    i_req_vaild[v.idx] = 1'b0;
    step();
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    int cnt;
    logic [2:0] exp_g [4];
    // Delay 3 lands ready on the last WAIT cycle before timeout: ready wins.
    vecs[0] = '{1, 1'b0, 32'h0000_FFF0, 32'h0,         3, 32'h1234_5678, 3'b010, 1'b0};
    vecs[1] = '{0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0BAD_F00D, 3'b001, 1'b0};
    vecs[2] = '{0, 1'b0, 32'h0000_2004, 32'h5555_AAAA, 1, 32'h0F0F_0F0F, 3'b001, 1'b0};
    vecs[3] = '{2, 1'b0, 32'h8000_0000, 32'h0,         2, 32'hA5A5_A5A5, 3'b100, 1'b0};

    i_reset_n = 1'b0;
    i_req_vaild = '0; i_req_write_enable = '0; i_req_lock = '0;
    i_req_address = '0; i_req_data_write = '0;
    i_bus_ready = 1'b0; i_bus_data_read = '0;
    repeat (2) step();
    chk("rst_bus_vld", 32'(o_bus_vaild), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    chk("rst_rdata", o_req_data_read, 32'd0);
    chk("rst_addr", o_bus_address, 32'd0);
    chk("rst_err", 32'(o_req_error), 32'd0);
    i_reset_n = 1'b1;
    step();

    foreach (vecs[i]) xfer(vecs[i]);

    // Locked read then write by requester 0 while requester 1 waits.
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0);
    step();
    chk("lk_vld1", 32'(o_bus_vaild), 32'd1);
    chk("lk_grant1", 32'(o_grant), 32'b001);
    chk("lk_addr1", o_bus_address, 32'h0000_0100);
    step();
    i_bus_ready = 1'b1; i_bus_data_read = 32'h1111_1111;
    sb.push_back('{3'b001, 32'h1111_1111, 1'b0});
    step();
    i_bus_ready = 1'b0;
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_0001);
    chk("lk_grant_resp", 32'(o_grant), 32'b001);
    step();
    chk("lk_grant_hold", 32'(o_grant), 32'b001);
    step();
    chk("lk_vld2", 32'(o_bus_vaild), 32'd1);
    chk("lk_grant2", 32'(o_grant), 32'b001);
    chk("lk_addr2", o_bus_address, 32'h0000_0104);
    chk("lk_we2", 32'(o_bus_write_enable), 32'd1);
    chk("lk_wdata2", o_bus_data_write, 32'hCAFE_0001);
    step();
    i_bus_ready = 1'b1; i_bus_data_read = 32'h2222_2222;
    sb.push_back('{3'b001, 32'h2222_2222, 1'b0});
    step();
    i_bus_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lk_grant_resp2", 32'(o_grant), 32'b001);
    step();
    chk("lk_release", 32'(o_grant), 32'b000);
    step();
    chk("lk_r1_grant", 32'(o_grant), 32'b010);
    chk("lk_r1_addr", o_bus_address, 32'h0000_0200);
    i_bus_ready = 1'b1; i_bus_data_read = 32'h3333_3333;
    sb.push_back('{3'b010, 32'h3333_3333, 1'b0});
    step();
    i_bus_ready = 1'b0;
    i_req_vaild[1] = 1'b0;
    step();
    chk("lk_drain", 32'(sb.size()), 32'd0);

    // Reset while a transfer is outstanding.
    set_req(1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h7777_7777);
    step();
    chk("rw_vld", 32'(o_bus_vaild), 32'd1);
    i_reset_n = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("rw_bus_vld", 32'(o_bus_vaild), 32'd0);
    chk("rw_grant", 32'(o_grant), 32'd0);
    chk("rw_addr", o_bus_address, 32'd0);
    chk("rw_wdata", o_bus_data_write, 32'd0);
    chk("rw_we", 32'(o_bus_write_enable), 32'd0);
    i_reset_n = 1'b1;
    repeat (2) step();
    chk("rw_idle_grant", 32'(o_grant), 32'd0);
    xfer('{2, 1'b0, 32'h0000_4000, 32'h0, 1, 32'h4444_4444, 3'b100, 1'b0});

    // Contention with all three requests held pending.
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, 1'b0, 1'b0, 32'h0000_A000 + 32'(k), 32'h0);
    for (int t = 0; t < 4; t++) begin
      int w;
      wait_bus();
      w = (exp_g[t] == 3'b001) ? 0 : (exp_g[t] == 3'b010) ? 1 : 2;
      chk("ct_grant", 32'(o_grant), 32'(exp_g[t]));
      chk("ct_addr", o_bus_address, 32'h0000_A000 + 32'(w));
      step();
      i_bus_ready = 1'b1; i_bus_data_read = 32'hC000_0000 + 32'(t);
      sb.push_back('{exp_g[t], 32'hC000_0000 + 32'(t), 1'b0});
      step();
      i_bus_ready = 1'b0;
      if (t == 3) i_req_vaild = 3'b000;
      step();
    end
    step();
    chk("ct_drain", 32'(sb.size()), 32'd0);

    // Timeout: data write, bus never answers.
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h9999_0000);
    step();
    sb.push_back('{3'b001, 32'hFFFF_FFFF, 1'b1});
    cnt = 0;
    while (o_bus_vaild && cnt < 20) begin
      cnt++;
      step();
    end
    chk("to_wait_cycles", 32'(cnt), 32'd4);
    i_req_vaild[0] = 1'b0;
    step();
    chk("to_drain", 32'(sb.size()), 32'd0);
    repeat (3) step();
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
